wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  Registered write-back stage with parametrised width and a memory-read wait.
//  - Selects the register-file write data from ALU, memory, link PC, immediate or special-register sources.
//  - Holds a load until the memory read returns, or until a bounded timeout expires.
//  - Presents one registered write (we/addr/data) to the register file.
//  - Sits between the MEM stage and the register file.
// PARAMETERS
//  DATA_W      16   data path width
//  SRC_W       8    width of the write-back source code
//  REG_AW      4    register address width
//  MEM_TIMEOUT 15   max cycles to wait for mem_rvalid after a load is accepted (>=1)
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        upstream op valid
//  in_ready    out  1        stage can accept; combinational, = (state==IDLE)
//  in_src      in   SRC_W    write-back source code (package constants)
//  in_we       in   1        op writes the register file
//  in_addr     in   REG_AW   destination register
//  in_ext      in   2        load extension mode (used only with LOAD_EXT_EN)
//  alu_result  in   DATA_W   ALU result
//  pc_link     in   DATA_W   return address for link ops
//  imm_data    in   DATA_W   extended immediate
//  sreg_data   in   DATA_W   special register (SP/IH/T) read value
//  mem_rdata   in   DATA_W   memory read data
//  mem_rvalid  in   1        mem_rdata valid this cycle
//  flush       in   1        kill the held or incoming op
//  wb_valid    out  1        write-back result valid (one-cycle pulse per op)
//  wb_we       out  1        register file write enable (= wb_valid & captured in_we)
//  wb_addr     out  REG_AW   register file address
//  wb_data     out  DATA_W   register file data
//  wb_err      out  1        one-cycle pulse: load timed out
// BEHAVIOUR
//  - Reset: state=IDLE, timeout count=0.
//    All outputs 0: wb_valid, wb_we, wb_addr, wb_data, wb_err. in_ready=1 in the cycle after reset.
//  - FSM states: IDLE, WAIT_MEM.
//  - Accept: an op is accepted on a rising edge where in_valid & in_ready & !flush.
//  - Source codes and captured data:
//      SRC_ALU   8'h17 -> alu_result
//      SRC_MEM   8'h18 -> mem_rdata (see load handling below)
//      SRC_LINK  8'h19 -> pc_link
//      SRC_IMM   8'h1A -> imm_data
//      SRC_SREG  8'h1B -> sreg_data
//      SRC_EMPTY 8'h0B and any undefined code -> data 0, wb_we forced 0
//  - Non-memory sources:
//      * Data is captured at the accept edge.
//      * wb_valid is high for exactly the next cycle (latency 1). State stays IDLE.
//      * Back-to-back accepts give back-to-back wb_valid pulses.
//  - SRC_MEM accept:
//      * Latch in_we, in_addr and in_ext; go to WAIT_MEM with count=0.
//      * mem_rvalid sampled in the accept cycle itself is ignored.
//  - WAIT_MEM, each edge:
//      * mem_rvalid=1: wb_data = ext(mem_rdata), wb_valid=1 next cycle, return to IDLE.
//      * mem_rvalid=0: count++.
//      * count reaches MEM_TIMEOUT-1 with no rvalid: return to IDLE and pulse wb_err next cycle.
//        On timeout wb_valid=0 and wb_we=0; no register write occurs.
//  - mem_rvalid in IDLE: ignored.
//  - flush:
//      * In IDLE: blocks the accept.
//      * In WAIT_MEM: return to IDLE with no wb_valid and no wb_err.
//      * Flush wins over a simultaneous mem_rvalid or timeout.
//      * Does not cancel a wb_valid pulse already registered.
//  - rst mid-WAIT_MEM: return to IDLE; the pending load is dropped; outputs return to reset values.
//  - Output hold: wb_addr and wb_data hold their last value while wb_valid=0; wb_we is 0 then.
//  - Widths: all data DATA_W; no arithmetic beyond the count, which is $clog2(MEM_TIMEOUT+1) bits.
// CONFIGURATION
//  LOAD_EXT_EN defined: ext() is applied per the latched in_ext:
//    00 full word
//    01 low byte, zero-extended
//    10 low byte, sign-extended
//    11 high byte, zero-extended
//  LOAD_EXT_EN undefined: in_ext is ignored and ext(x)=x.
// STRUCTURE
//  - Shared package wb_pkg: SRC_* code constants, EXT_* mode constants, FSM state encoding.
//  - One sub-module: wb_load_ext (combinational byte/sign extender).
//    Instantiated only under LOAD_EXT_EN.
//  - Everything else (FSM, timeout counter, output registers) lives in wb_select_stage.
// TESTING
//  1. Reset, then accept SRC_ALU with alu_result=16'h1234, addr=3, we=1.
//     -> next cycle: wb_valid=1, wb_we=1, wb_addr=3, wb_data=16'h1234. Following cycle: wb_valid=0.
//  2. Accept SRC_MEM (addr=5); mem_rvalid with 16'hBEEF three cycles later.
//     -> in_ready=0 while waiting; wb_data=16'hBEEF and wb_valid=1 the cycle after rvalid.
//  3. Accept SRC_MEM with MEM_TIMEOUT=4 and no rvalid.
//     -> wb_err pulses once, after 4 wait cycles; wb_we never asserts; in_ready=1 afterwards.
//  4. In WAIT_MEM, assert flush and mem_rvalid together.
//     -> no wb_valid, no wb_err; IDLE next cycle.
//  5. Back-to-back SRC_LINK (16'h0040) then SRC_EMPTY (we=1).
//     -> wb_valid on two consecutive cycles; the second has wb_we=0 and wb_data=0.
//  6. With LOAD_EXT_EN, in_ext=10, mem_rdata=16'h0080 -> wb_data=16'hFF80.
//     rst asserted mid-wait -> all outputs 0 and the load is dropped.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the write-back select stage: source codes, load
// extension modes and the FSM state encoding.
package wb_pkg;

  localparam logic [7:0] SRC_ALU   = 8'h17;
  localparam logic [7:0] SRC_MEM   = 8'h18;
  localparam logic [7:0] SRC_LINK  = 8'h19;
  localparam logic [7:0] SRC_IMM   = 8'h1A;
  localparam logic [7:0] SRC_SREG  = 8'h1B;
  localparam logic [7:0] SRC_EMPTY = 8'h0B;

  localparam logic [1:0] EXT_FULL = 2'b00;
  localparam logic [1:0] EXT_LBU  = 2'b01;
  localparam logic [1:0] EXT_LB   = 2'b10;
  localparam logic [1:0] EXT_HBU  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational byte/sign extender for load data; used only when the
// stage is built with LOAD_EXT_EN.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (mode_i)
      EXT_FULL: data_o = data_i;
      EXT_LBU:  data_o = {{(DATA_W-8){1'b0}}, data_i[7:0]};
      EXT_LB:   data_o = {{(DATA_W-8){data_i[7]}}, data_i[7:0]};
      EXT_HBU:  data_o = {{(DATA_W-8){1'b0}}, data_i[15:8]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back stage: selects the register-file write source and
// waits (bounded) for load data. Define LOAD_EXT_EN to enable load extension.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SRC_W       = 8,
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SRC_W-1:0]  in_src,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [1:0]        in_ext,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_link,
  input  logic [DATA_W-1:0] imm_data,
  input  logic [DATA_W-1:0] sreg_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  // Upstream handshake: an op transfers on a rising edge with
  // in_valid & in_ready & !flush; in_ready depends only on the state.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_lat_q, we_lat_d;
  logic [REG_AW-1:0] addr_lat_q, addr_lat_d;
  logic [1:0]        ext_lat_q, ext_lat_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_err_q, wb_err_d;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] src_data;
  logic              src_we;
  logic              src_is_mem;

`ifdef LOAD_EXT_EN
  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .mode_i (ext_lat_q),
    .data_i (mem_rdata),
    .data_o (load_data)
  );
`else
  logic unused_ext;
  assign unused_ext = ^ext_lat_q;
  assign load_data  = mem_rdata;
`endif

  // Undefined codes and SRC_EMPTY still produce a write-back pulse, but never a write.
  always_comb begin
    src_data   = '0;
    src_we     = 1'b0;
    src_is_mem = 1'b0;
    case (in_src)
      SRC_W'(SRC_ALU):  begin src_data = alu_result; src_we = in_we; end
      SRC_W'(SRC_MEM):  src_is_mem = 1'b1;
      SRC_W'(SRC_LINK): begin src_data = pc_link;    src_we = in_we; end
      SRC_W'(SRC_IMM):  begin src_data = imm_data;   src_we = in_we; end
      SRC_W'(SRC_SREG): begin src_data = sreg_data;  src_we = in_we; end
      default:          ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_lat_d   = we_lat_q;
    addr_lat_d = addr_lat_q;
    ext_lat_d  = ext_lat_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_err_d   = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (src_is_mem) begin
            state_d    = ST_WAIT_MEM;
            cnt_d      = '0;
            we_lat_d   = in_we;
            addr_lat_d = in_addr;
            ext_lat_d  = in_ext;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = src_we;
            wb_addr_d  = in_addr;
            wb_data_d  = src_data;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Priority: flush, then returning data, then timeout.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (mem_rvalid) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_we_d    = we_lat_q;
          wb_addr_d  = addr_lat_q;
          wb_data_d  = load_data;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          wb_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_lat_q   <= 1'b0;
      addr_lat_q <= '0;
      ext_lat_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_lat_q   <= we_lat_d;
      addr_lat_q <= addr_lat_d;
      ext_lat_q  <= ext_lat_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_wb_select_stage;
  import wb_pkg::*;

  localparam int DATA_W  = 16;
  localparam int SRC_W   = 8;
  localparam int REG_AW  = 4;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SRC_W-1:0]  in_src = '0;
  logic              in_we = 1'b0;
  logic [REG_AW-1:0] in_addr = '0;
  logic [1:0]        in_ext = '0;
  logic [DATA_W-1:0] alu_result = '0, pc_link = '0, imm_data = '0, sreg_data = '0, mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              flush = 1'b0;
  logic              wb_valid, wb_we, wb_err;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  state_e            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  wb_select_stage #(
    .DATA_W(DATA_W), .SRC_W(SRC_W), .REG_AW(REG_AW), .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
    .in_we(in_we), .in_addr(in_addr), .in_ext(in_ext), .alu_result(alu_result),
    .pc_link(pc_link), .imm_data(imm_data), .sreg_data(sreg_data), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .flush(flush), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_err(wb_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] ext_f(input logic [1:0] m, input logic [DATA_W-1:0] x);
`ifdef LOAD_EXT_EN
    int v;
    case (m)
      2'd0: return x;
      2'd1: return x % 256;
      2'd2: begin
        v = x % 256;
        if (v >= 128) v = v - 256;
        return DATA_W'(v);
      end
      default: return (x / 256) % 256;
    endcase
`else
    return x;
`endif
  endfunction

  // A busy load remembers how many wait cycles it has spent; a
  // write-back is predicted as the {we, addr, data} tuple it must carry.
  bit                m_busy = 1'b0;
  int                m_waited = 0;
  bit                m_we;
  logic [REG_AW-1:0] m_addr;
  logic [1:0]        m_ext;
  bit                e_valid = 0, e_we = 0, e_err = 0;
  logic [REG_AW-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  logic [DATA_W+REG_AW:0] exp_q[$];

  always @(posedge clk) begin
    e_valid = 0;
    e_we    = 0;
    e_err   = 0;
    if (rst) begin
      m_busy = 0;
      e_addr = '0;
      e_data = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid && !flush) begin
        if (in_src == SRC_MEM) begin
          m_busy = 1; m_waited = 0; m_we = in_we; m_addr = in_addr; m_ext = in_ext;
        end else begin
          e_valid = 1;
          e_addr  = in_addr;
          e_we    = in_we;
          if (in_src == SRC_ALU)       e_data = alu_result;
          else if (in_src == SRC_LINK) e_data = pc_link;
          else if (in_src == SRC_IMM)  e_data = imm_data;
          else if (in_src == SRC_SREG) e_data = sreg_data;
          else begin e_data = '0; e_we = 0; end
        end
      end
    end else begin
      m_waited++;
      if (flush) m_busy = 0;
      else if (mem_rvalid) begin
        m_busy = 0; e_valid = 1; e_we = m_we; e_addr = m_addr; e_data = ext_f(m_ext, mem_rdata);
      end else if (m_waited == TIMEOUT) begin
        m_busy = 0; e_err = 1;
      end
    end
    if (e_valid) exp_q.push_back({e_we, e_addr, e_data});
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [DATA_W+REG_AW:0] got;
    if (chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("wb_valid", wb_valid, e_valid);
      chk("wb_we",    wb_we,    e_we);
      chk("wb_err",   wb_err,   e_err);
      chk("wb_addr",  wb_addr,  e_addr);
      chk("wb_data",  wb_data,  e_data);
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_wb", 1, 0);
        else begin
          got = exp_q.pop_front();
          chk("sb_wb_tuple", {wb_we, wb_addr, wb_data}, got);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] src, input logic we, input logic [REG_AW-1:0] addr,
                       input logic [1:0] ext);
    in_valid = 1'b1; in_src = src; in_we = we; in_addr = addr; in_ext = ext;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] codes[8];
    codes = '{SRC_ALU, SRC_MEM, SRC_LINK, SRC_IMM, SRC_SREG, SRC_EMPTY, SRC_MEM, 8'h00};

    do_reset();
    chk_en = 1'b1;
    chk("rst_ready", in_ready, 1);
    chk("rst_outs", {wb_valid, wb_we, wb_addr, wb_data, wb_err}, '0);

    // 1: ALU op
    alu_result = 16'h1234;
    issue(SRC_ALU, 1'b1, 4'd3, 2'd0);
    chk("t1_wb", {wb_valid, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, 4'd3, 16'h1234});
    step();
    chk("t1_pulse_end", wb_valid, 0);

    // 2: load returning three cycles after accept
    issue(SRC_MEM, 1'b1, 4'd5, 2'd0);
    chk("t2_ready0_a", in_ready, 0);
    step();
    chk("t2_ready0_b", in_ready, 0);
    step();
    chk("t2_ready0_c", in_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_rvalid = 1'b0;
    chk("t2_wb", {wb_valid, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, 4'd5, 16'hBEEF});
    step();
    chk("t2_after", {wb_valid, in_ready}, 2'b01);

    // 3: load timeout after TIMEOUT wait cycles
    issue(SRC_MEM, 1'b1, 4'd6, 2'd0);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk("t3_no_err_yet", {wb_err, wb_valid}, 2'b00);
    end
    step();
    chk("t3_err", {wb_err, wb_valid, wb_we}, 3'b100);
    step();
    chk("t3_after", {wb_err, in_ready}, 2'b01);

    // 4: flush beats simultaneous rvalid
    issue(SRC_MEM, 1'b1, 4'd7, 2'd0);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    step();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("t4_flush", {wb_valid, wb_err, in_ready}, 3'b001);
    step();
    chk("t4_after", {wb_valid, wb_err}, 2'b00);

    // 5: back-to-back LINK then EMPTY
    pc_link = 16'h0040;
    issue(SRC_LINK, 1'b1, 4'd2, 2'd0);
    chk("t5_link", {wb_valid, wb_we, wb_data}, {1'b1, 1'b1, 16'h0040});
    issue(SRC_EMPTY, 1'b1, 4'd9, 2'd0);
    chk("t5_empty", {wb_valid, wb_we, wb_data}, {1'b1, 1'b0, 16'h0000});
    step();

`ifdef LOAD_EXT_EN
    // 6a: sign-extended low byte
    issue(SRC_MEM, 1'b1, 4'd4, 2'b10);
    mem_rvalid = 1'b1; mem_rdata = 16'h0080;
    step();
    mem_rvalid = 1'b0;
    chk("t6_sext", wb_data, 16'hFF80);
    step();
`endif

    // 6b: reset in the middle of a wait
    issue(SRC_MEM, 1'b1, 4'd8, 2'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_outs", {wb_valid, wb_we, wb_addr, wb_data, wb_err}, '0);
    chk("t6_rst_ready", in_ready, 1);
    mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
    step();
    mem_rvalid = 1'b0;
    chk("t6_dropped", wb_valid, 0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_src     = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) in_src = 8'($urandom);
      in_we      = 1'($urandom);
      in_addr    = 4'($urandom);
      in_ext     = 2'($urandom);
      alu_result = 16'($urandom);
      pc_link    = 16'($urandom);
      imm_data   = 16'($urandom);
      sreg_data  = 16'($urandom);
      mem_rdata  = 16'($urandom);
      mem_rvalid = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
    end
    in_valid = 1'b0; rst = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
